// File: rtl/sdiv16x8_pkg.sv
// Shared types and constants for the sequential signed divider sdiv16x8.
package div8_pkg;

    localparam int DIV_DW   = 16;
    localparam int DIV_QW   = 8;
    localparam int DIV_ITER = 16;

    localparam logic [7:0] Q_POS_MAX = 8'h7F;
    localparam logic [7:0] Q_NEG_MAX = 8'h80;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

endpackage

// File: rtl/sdiv16x8_if.sv
// Start/done handshake, operand and result bundle for sdiv16x8.
interface sdiv16x8_if #(
    parameter int DW = div8_pkg::DIV_DW,
    parameter int QW = div8_pkg::DIV_QW
);
    logic          start;
    logic [DW-1:0] dividend;
    logic [QW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [QW-1:0] quotient;
    logic [QW-1:0] remainder;
    logic          ovf;
    logic          dbz;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, ovf, dbz
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, ovf, dbz
    );
endinterface

// File: rtl/sdiv16x8_abs.sv
// Two's-complement to magnitude converter; one extra bit keeps the most negative value exact.
module sdiv_abs #(
    parameter int W = 8
) (
    input  logic [W-1:0] value,
    output logic [W:0]   mag
);
    logic [W:0] ext;

    assign ext = {value[W-1], value};
    assign mag = value[W-1] ? -ext : ext;
endmodule

// File: rtl/sdiv16x8.sv
// Radix-2 restoring signed divider, one quotient bit per cycle, fixed 18-cycle latency.
// Define DIV8_SAT_EN to saturate an overflowing quotient instead of wrapping it.
module sdiv16x8 #(
    parameter int DW = div8_pkg::DIV_DW,
    parameter int QW = div8_pkg::DIV_QW
) (
    input  logic         clk,
    input  logic         rst,
    sdiv16x8_if.slave    bus
);
    import div8_pkg::*;

    localparam int             CW       = $clog2(DW);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DW - 1);
    localparam logic [DW-1:0]  LIM_POS  = DW'((1 << (QW - 1)) - 1);
    localparam logic [DW-1:0]  LIM_NEG  = DW'(1 << (QW - 1));

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   dvd_r;
    logic [DW-1:0]   q_r;
    logic [QW:0]     rem_r;
    logic [QW:0]     dvs_r;
    logic [QW-1:0]   dvd_lo_r;
    logic            sign_q;
    logic            sign_r;
    logic            dbz_r;
    logic [QW-1:0]   res_q;
    logic [QW-1:0]   res_r;
    logic            res_ovf;
    logic            res_dbz;

    logic [DW:0]     dvd_abs;
    logic [QW:0]     dvs_abs;
    logic [QW:0]     shifted;
    logic [QW+1:0]   diff;
    logic            fits;
    logic [DW-1:0]   q_s;
    logic [QW-1:0]   rem_s;
    logic            q_ovf;
    logic            unused_bits;

    sdiv_abs #(.W(DW)) u_abs_dvd (.value(bus.dividend), .mag(dvd_abs));
    sdiv_abs #(.W(QW)) u_abs_dvs (.value(bus.divisor),  .mag(dvs_abs));

    // Trial subtraction of the divisor magnitude from the shifted partial remainder.
    assign shifted = {rem_r[QW-1:0], dvd_r[DW-1]};
    assign diff    = {1'b0, shifted} - {1'b0, dvs_r};
    assign fits    = ~diff[QW+1];

    // Sign application mirrors sdiv_abs; magnitude limits differ by one for a negative quotient.
    assign q_s   = sign_q ? -q_r : q_r;
    assign rem_s = sign_r ? -rem_r[QW-1:0] : rem_r[QW-1:0];
    assign q_ovf = sign_q ? (q_r > LIM_NEG) : (q_r > LIM_POS);

    assign unused_bits = ^{rem_r[QW], dvd_abs[DW], q_s[DW-1:QW]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            dvd_r         <= '0;
            q_r           <= '0;
            rem_r         <= '0;
            dvs_r         <= '0;
            dvd_lo_r      <= '0;
            sign_q        <= 1'b0;
            sign_r        <= 1'b0;
            dbz_r         <= 1'b0;
            res_q         <= '0;
            res_r         <= '0;
            res_ovf       <= 1'b0;
            res_dbz       <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.ovf       <= 1'b0;
            bus.dbz       <= 1'b0;
        end else begin
            // NOTE: done defaults low every cycle so the DONE branch yields a single-cycle pulse.
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.done) begin
                        dvd_r    <= dvd_abs[DW-1:0];
                        dvs_r    <= dvs_abs;
                        dvd_lo_r <= bus.dividend[QW-1:0];
                        sign_q   <= bus.dividend[DW-1] ^ bus.divisor[QW-1];
                        sign_r   <= bus.dividend[DW-1];
                        dbz_r    <= (bus.divisor == '0);
                        rem_r    <= '0;
                        q_r      <= '0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    rem_r <= fits ? diff[QW:0] : shifted;
                    q_r   <= {q_r[DW-2:0], fits};
                    dvd_r <= {dvd_r[DW-2:0], 1'b0};
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (dbz_r) begin
                        res_q   <= sign_r ? Q_NEG_MAX : Q_POS_MAX;
                        res_r   <= dvd_lo_r;
                        res_ovf <= 1'b1;
                        res_dbz <= 1'b1;
                    end else begin
`ifdef DIV8_SAT_EN
                        res_q   <= q_ovf ? (sign_q ? Q_NEG_MAX : Q_POS_MAX) : q_s[QW-1:0];
`else
                        res_q   <= q_s[QW-1:0];
`endif
                        res_r   <= rem_s;
                        res_ovf <= q_ovf;
                        res_dbz <= 1'b0;
                    end
                    bus.busy <= 1'b0;
                    state    <= DONE;
                end
                DONE: begin
                    bus.quotient  <= res_q;
                    bus.remainder <= res_r;
                    bus.ovf       <= res_ovf;
                    bus.dbz       <= res_dbz;
                    bus.done      <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdiv16x8.sv
// Scoreboard bench for sdiv16x8: directed vectors, handshake abuse and mid-operation reset.
module tb_sdiv16x8;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       ovf;
        logic       dbz;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    exp_t sb[$];

    sdiv16x8_if bus ();

    sdiv16x8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ovq(input logic [7:0] wrap, input logic [7:0] sat);
`ifdef DIV8_SAT_EN
        return sat;
`else
        return wrap;
`endif
    endfunction

    // Monitor: every done must match the oldest outstanding expectation, on its exact cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.done) begin
            check("done_expected", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("quotient",  bus.quotient,  e.q);
                check("remainder", bus.remainder, e.r);
                check("ovf",       bus.ovf,       e.ovf);
                check("dbz",       bus.dbz,       e.dbz);
                check("latency",   cyc,           e.due);
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic [7:0] b, input logic [7:0] q,
                         input logic [7:0] r, input logic ovf, input logic dbz);
        @(negedge clk);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        sb.push_back('{q, r, ovf, dbz, cyc + 19});
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = 16'hA5C3;
        bus.divisor  = 8'h5A;
        check("busy_run", bus.busy, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        check("drain", sb.size(), 0);
        @(negedge clk);
    endtask

    task automatic run(input logic [15:0] a, input logic [7:0] b, input logic [7:0] q,
                       input logic [7:0] r, input logic ovf, input logic dbz);
        issue(a, b, q, r, ovf, dbz);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #12;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_quotient", bus.quotient, 0);
        check("rst_remainder", bus.remainder, 0);
        check("rst_ovf", bus.ovf, 0);
        check("rst_dbz", bus.dbz, 0);
        @(negedge clk);
        rst = 1'b0;

        run(16'h1234, 8'h25, 8'h7D, 8'h23, 1'b0, 1'b0);
        run(16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0);
        run(16'h4000, 8'h80, 8'h80, 8'h00, 1'b0, 1'b0);
        run(16'h4000, 8'h02, ovq(8'h00, 8'h7F), 8'h00, 1'b1, 1'b0);
        run(16'h8000, 8'hFF, ovq(8'h00, 8'h7F), 8'h00, 1'b1, 1'b0);
        run(16'h8000, 8'h80, ovq(8'h00, 8'h7F), 8'h00, 1'b1, 1'b0);
        run(16'hFC00, 8'h08, 8'h80, 8'h00, 1'b0, 1'b0);
        run(16'h0400, 8'h08, ovq(8'h80, 8'h7F), 8'h00, 1'b1, 1'b0);
        run(16'h7FFF, 8'h7F, ovq(8'h02, 8'h7F), 8'h01, 1'b1, 1'b0);
        run(16'h0007, 8'hFD, 8'hFE, 8'h01, 1'b0, 1'b0);
        run(16'hFFF6, 8'h05, 8'hFE, 8'h00, 1'b0, 1'b0);
        run(16'hFF85, 8'h00, 8'h80, 8'h85, 1'b1, 1'b1);
        run(16'h0050, 8'h00, 8'h7F, 8'h50, 1'b1, 1'b1);

        // Second start sampled at E5 while busy: no extra done may appear.
        issue(16'h1234, 8'h25, 8'h7D, 8'h23, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        bus.dividend = 16'h0050;
        bus.divisor  = 8'h00;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        check("busy_ignore", bus.busy, 1);
        wait_idle();
        repeat (25) @(negedge clk);

        // Leave nonzero flags behind, then abort the next operation at E9.
        run(16'h0050, 8'h00, 8'h7F, 8'h50, 1'b1, 1'b1);
        issue(16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_quotient", bus.quotient, 0);
        check("abort_remainder", bus.remainder, 0);
        check("abort_ovf", bus.ovf, 0);
        check("abort_dbz", bus.dbz, 0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("idle_after_abort", bus.busy, 0);

        run(16'h1234, 8'h25, 8'h7D, 8'h23, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sdiv16x8.md
Name: sdiv16x8

Overview:
- Sequential signed divider, the inverse of the team's signed 8x8 multiplier.
- Takes a 16-bit two's-complement dividend (product-width) and an 8-bit two's-complement divisor.
- Returns an 8-bit quotient and an 8-bit remainder; quotient truncates toward zero, remainder takes the dividend's sign.
- Radix-2 restoring, one quotient bit per cycle, start/done handshake; sits in the arithmetic datapath beside mult8x8.

Parameters:
DW, 16, dividend width (also the iteration count)
QW, 8, divisor, quotient and remainder width

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request; sampled only in IDLE
dividend  input  16  signed dividend, sampled with start
divisor  input  8  signed divisor, sampled with start
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse; results valid from this cycle
quotient  output  8  signed quotient, held until next done
remainder  output  8  signed remainder, held until next done
ovf  output  1  quotient not representable in 8 bits, or divide-by-zero
dbz  output  1  divisor was zero

Behaviour:
- Reset: state=IDLE; busy, done, ovf, dbz = 0; quotient, remainder = 8'h00.
- Reset is asynchronous; mid-operation it aborts and discards the operation.
- States:
  - IDLE: on start, latch |dividend| (17-bit safe for -32768), |divisor| (9-bit safe for -128), sign_q = dividend[15]^divisor[7], sign_r = dividend[15], dbz_r = (divisor==0). Go to CALC with cnt=0.
  - CALC: 16 cycles. Each cycle: shift remainder left, shift in the next dividend MSB, trial-subtract |divisor|. If result >= 0, keep it and set q bit = 1. cnt++; after cnt=15 go to FIX.
  - FIX: apply signs. Overflow check: magnitude > 127 when sign_q=0, or > 128 when sign_q=1. Register outputs, go to DONE.
  - DONE: done=1 for exactly this cycle; busy=0; return to IDLE. The next start is accepted in the following cycle.
- Latency: start sampled at edge E0; done high during the cycle after edge E18. Fixed for all operands, including dbz.
- busy=1 in CALC and FIX.
- start while busy or done is ignored; operands may change freely after acceptance.
- Divide-by-zero: still runs the full latency.
  - dbz=1, ovf=1.
  - quotient = 8'h7F if dividend >= 0, else 8'h80.
  - remainder = dividend[7:0].
- Remainder magnitude is always < |divisor| <= 128, so it always fits. Zero remainder is positive zero.
- ovf and dbz are held with quotient/remainder until the next done.

Optional Feature:
- Macro: DIV8_SAT_EN.
- Defined: on non-dbz overflow, quotient saturates to 8'h7F (positive) or 8'h80 (negative); ovf=1.
- Undefined: on overflow, quotient = low 8 bits of the signed-applied 16-bit quotient (wraps); ovf still 1.
- The dbz result is unaffected by the macro.

Decomposition:
- Package div8_pkg:
  - state enum {IDLE, CALC, FIX, DONE}
  - localparams DIV_DW=16, DIV_QW=8, DIV_ITER=16
  - constants Q_POS_MAX=8'h7F, Q_NEG_MAX=8'h80
- One sub-module, sdiv_abs: parameterised-width two's-complement to magnitude converter. Instantiated for dividend (16→17) and divisor (8→9); its logic is reused in reverse in FIX for sign application.

Test Plan:
- dividend=16'h1234 (4660), divisor=8'h25 (37) -> done at E18; quotient=8'h7D (125), remainder=8'h23 (35), ovf=0, dbz=0.
- dividend=16'hFF9C (-100), divisor=8'h07 -> quotient=8'hF2 (-14), remainder=8'hFE (-2), ovf=0.
- dividend=16'h4000 (16384), divisor=8'h80 (-128) -> quotient=8'h80, remainder=8'h00, ovf=0. dividend=16'h4000, divisor=8'h02 -> ovf=1; quotient=8'h7F with DIV8_SAT_EN, 8'h00 without.
- dividend=16'h8000 (-32768), divisor=8'hFF (-1) -> ovf=1; quotient=8'h7F with DIV8_SAT_EN, 8'h00 without; remainder=8'h00.
- dividend=16'h0050, divisor=8'h00 -> dbz=1, ovf=1, quotient=8'h7F, remainder=8'h50, same latency.
- Handshake/reset:
  - Second start pulsed at E5 during busy -> ignored; exactly one done.
  - rst asserted at E9 -> busy=0 and outputs=0 immediately; no done follows.
  - start after reset release -> normal result.
